// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, fetches one word per instruction over a
// req/rvalid handshake, holds it for decode and selects the next PC from redirects.
//
// state | meaning
// IDLE  | out of reset, request issued next cycle
// FETCH | imem_req high at pc, waiting for imem_rvalid
// HOLD  | instruction valid, waiting for instr_ready handshake
// ERR   | misaligned next PC trapped, parked until rst
module instr_fetch_unit #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_rvalid,
   input  logic [31:0]     imem_rdata,
   output logic [31:0]     instruction,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_plus4,
   input  logic            branch_taken,
   input  logic            jl,
   input  logic            jlr,
   input  logic [XLEN-1:0] branch_target,
   input  logic [XLEN-1:0] jalr_target,
   output logic            fetch_err
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {IDLE, FETCH, HOLD, ERR} state_t;

   state_t          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d, next_pc;
   logic [31:0]     instr_q, instr_d;
   logic            valid_q, valid_d;
   logic            err_q, err_d;

   assign pc_plus4    = pc_q + {{(XLEN-3){1'b0}}, 3'd4};
   assign pc          = pc_q;
   assign imem_addr   = pc_q;
   assign instruction = instr_q;
   assign instr_valid = valid_q;
   assign fetch_err   = err_q;

   // jalr clears bit 0 of the ALU result; jal and branches share branch_target
   always_comb begin
      if (jlr)
         next_pc = {jalr_target[XLEN-1:1], 1'b0};
      else if (jl || branch_taken)
         next_pc = branch_target;
      else
         next_pc = pc_plus4;
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      instr_d  = instr_q;
      valid_d  = valid_q;
      err_d    = err_q;
      imem_req = 1'b0;
      unique case (state_q)
         IDLE: state_d = FETCH;
         FETCH: begin
            imem_req = 1'b1;
            if (imem_rvalid) begin
               instr_d = imem_rdata;
               valid_d = 1'b1;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (instr_ready) begin
               valid_d = 1'b0;
               if (next_pc[1:0] == 2'b00) begin
                  pc_d    = next_pc;
                  state_d = FETCH;
               end else begin
                  err_d   = 1'b1;
                  state_d = ERR;
               end
            end
         end
         ERR: state_d = ERR;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         instr_q <= NOP;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

`ifndef SYNTHESIS
   rvalid_only_in_fetch: assert property (@(posedge clk) disable iff (rst)
      imem_rvalid |-> (state_q == FETCH))
      else $error("imem_rvalid received outside FETCH");
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed redirect table, multi-cycle corner sequences and
// a randomized run checked against a transaction-level PC/instruction model.
module tb_instr_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0000_0100;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] instruction;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        branch_taken;
   logic        jl;
   logic        jlr;
   logic [31:0] branch_target;
   logic [31:0] jalr_target;
   logic        fetch_err;

   instr_fetch_unit #(.XLEN(32), .RESET_PC(RST_PC)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .instruction(instruction), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .pc(pc), .pc_plus4(pc_plus4),
      .branch_taken(branch_taken), .jl(jl), .jlr(jlr),
      .branch_target(branch_target), .jalr_target(jalr_target),
      .fetch_err(fetch_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        jlr, jl, bt;
      logic [31:0] btgt, jtgt, exp_addr;
   } vec_t;

   vec_t        vecs[8];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] exp_pc;
   logic        last_err;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic clear_redirect();
      jlr = 0; jl = 0; branch_taken = 0; branch_target = 0; jalr_target = 0;
   endtask

   task automatic do_reset();
      rst = 1; imem_rvalid = 0; instr_ready = 0; clear_redirect();
      step(); step();
      rst = 0;
      exp_pc = RST_PC;
      chk("rst_req", imem_req, 0);
      chk("rst_valid", instr_valid, 0);
      chk("rst_instr", instruction, NOP);
      chk("rst_pc", pc, RST_PC);
      chk("rst_err", fetch_err, 0);
   endtask

   // Memory side: wait for a request, answer after 1+extra cycles
   task automatic serve(input logic [31:0] data, input int extra);
      int n = 0;
      while (!imem_req && n < 20) begin step(); n++; end
      chk("req_timeout", imem_req, 1);
      chk("req_addr", imem_addr, exp_pc);
      for (int i = 0; i < extra; i++) begin
         step();
         chk("req_held", imem_req, 1);
      end
      imem_rvalid = 1; imem_rdata = data;
      step();
      imem_rvalid = 0; imem_rdata = $urandom;
      chk("valid_after_rvalid", instr_valid, 1);
      chk("instr_latched", instruction, data);
      chk("pc_at_hold", pc, exp_pc);
      chk("req_drop", imem_req, 0);
   endtask

   task automatic hold_cycles(input int n, input logic [31:0] data);
      for (int i = 0; i < n; i++) begin
         jlr = 1'($urandom); jl = 1'($urandom); branch_taken = 1'($urandom);
         branch_target = $urandom; jalr_target = $urandom;
         step();
         chk("bp_valid", instr_valid, 1);
         chk("bp_instr", instruction, data);
         chk("bp_pc", pc, exp_pc);
         chk("bp_req", imem_req, 0);
      end
      clear_redirect();
   endtask

   task automatic retire(input logic jlr_i, input logic jl_i, input logic bt_i,
                         input logic [31:0] btgt_i, input logic [31:0] jtgt_i);
      logic [31:0] tgt;
      if (jlr_i)             tgt = jtgt_i & 32'hFFFF_FFFE;
      else if (jl_i || bt_i) tgt = btgt_i;
      else                   tgt = exp_pc + 32'd4;
      last_err = (tgt % 4) != 0;
      chk("pc_plus4", pc_plus4, exp_pc + 32'd4);
      jlr = jlr_i; jl = jl_i; branch_taken = bt_i;
      branch_target = btgt_i; jalr_target = jtgt_i; instr_ready = 1;
      step();
      instr_ready = 0; clear_redirect();
      chk("valid_after_hs", instr_valid, 0);
      if (last_err) begin
         chk("err_set", fetch_err, 1);
         chk("err_req", imem_req, 0);
         chk("err_pc", pc, exp_pc);
      end else begin
         chk("hs_err", fetch_err, 0);
         chk("hs_req", imem_req, 1);
         chk("hs_addr", imem_addr, tgt);
         exp_pc = tgt;
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not finish, got running expected done");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = '{0, 0, 0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0104};
      vecs[1] = '{0, 0, 1, 32'h0000_0200, 32'h0000_0777, 32'h0000_0200};
      vecs[2] = '{1, 0, 1, 32'h0000_0180, 32'h0000_0305, 32'h0000_0304};
      vecs[3] = '{0, 1, 0, 32'h0000_0040, 32'h0000_0999, 32'h0000_0040};
      vecs[4] = '{0, 1, 1, 32'h0000_0080, 32'h0000_0001, 32'h0000_0080};
      vecs[5] = '{1, 0, 0, 32'h0000_0003, 32'hFFFF_FFFD, 32'hFFFF_FFFC};
      vecs[6] = '{0, 0, 0, 32'h0000_0555, 32'h0000_0002, 32'h0000_0000};
      vecs[7] = '{1, 1, 1, 32'h0000_0555, 32'h0000_0011, 32'h0000_0010};

      imem_rdata = 0;
      do_reset();

      // Directed redirect chain starting from RST_PC
      for (int i = 0; i < 8; i++) begin
         serve(32'h0050_0093 + i, 0);
         if (i == 0) hold_cycles(5, 32'h0050_0093);
         if (i == 6) chk("wrap_pc_plus4", pc_plus4, 32'h0000_0000);
         retire(vecs[i].jlr, vecs[i].jl, vecs[i].bt, vecs[i].btgt, vecs[i].jtgt);
         chk("vec_addr", imem_addr, vecs[i].exp_addr);
      end

      // Misaligned jal target traps into ERR until reset
      serve(32'h0000_006F, 1);
      retire(0, 1, 0, 32'h0000_0202, 32'h0);
      chk("mis_pc", pc, 32'h0000_0010);
      for (int i = 0; i < 3; i++) begin
         instr_ready = 1'($urandom);
         step();
         chk("err_sticky", fetch_err, 1);
         chk("err_no_req", imem_req, 0);
         chk("err_no_valid", instr_valid, 0);
      end
      instr_ready = 0;
      do_reset();
      step();
      chk("restart_req", imem_req, 1);
      chk("restart_addr", imem_addr, RST_PC);

      // Reset mid-fetch, then a late response while held in reset/IDLE
      serve(32'h1111_1111, 0);
      retire(0, 0, 0, 32'h0, 32'h0);
      rst = 1;
      step();
      chk("midrst_req", imem_req, 0);
      chk("midrst_valid", instr_valid, 0);
      chk("midrst_pc", pc, RST_PC);
      chk("midrst_instr", instruction, NOP);
      imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF;
      step();
      imem_rvalid = 0; rst = 0;
      exp_pc = RST_PC;
      chk("late_rvalid_instr", instruction, NOP);
      chk("late_rvalid_valid", instr_valid, 0);

      // Reset coinciding with a response: reset wins
      serve(32'h2222_2222, 0);
      retire(0, 0, 0, 32'h0, 32'h0);
      rst = 1; imem_rvalid = 1; imem_rdata = 32'h3333_3333;
      step();
      rst = 0; imem_rvalid = 0;
      exp_pc = RST_PC;
      chk("rst_rvalid_instr", instruction, NOP);
      chk("rst_rvalid_valid", instr_valid, 0);

      // Randomized run against the transaction model
      for (int k = 0; k < 200; k++) begin
         logic [31:0] data, bt_t, jt_t;
         logic        r_jlr, r_jl, r_bt, misal;
         int          kind;
         data = $urandom;
         serve(data, $urandom_range(0, 2));
         hold_cycles($urandom_range(0, 2), data);
         kind  = $urandom_range(0, 3);
         misal = ($urandom_range(0, 9) == 0);
         r_jlr = (kind == 3);
         r_jl  = (kind == 2) || (kind == 3 && $urandom_range(0, 1) == 1);
         r_bt  = (kind == 1) || (kind >= 2 && $urandom_range(0, 1) == 1);
         bt_t  = $urandom & 32'hFFFF_FFFC;
         jt_t  = $urandom & 32'hFFFF_FFFD;
         if (misal) begin
            if (r_jlr) jt_t = jt_t | 32'h2;
            else bt_t = bt_t | 32'($urandom_range(1, 3));
         end
         retire(r_jlr, r_jl, r_bt, bt_t, jt_t);
         if (last_err) begin
            step();
            chk("rnd_err_sticky", fetch_err, 1);
            do_reset();
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front-end stage of the single-cycle RV32I core; sits directly upstream of the instruction decoder/control unit.
- Owns the PC register and fetches one 32-bit word per instruction from instruction memory over a request/response handshake.
- Presents a held, valid instruction word to decode and computes the next PC from redirect inputs (branch, jal, jalr) resolved by the downstream datapath.
- Traps misaligned targets into a sticky error state.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- XLEN, 32, address/data width; only 32 is supported.

Ports:
- clk  in  1  core clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- imem_req  out  1  fetch request; held high until imem_rvalid
- imem_addr  out  XLEN  fetch address, equals pc while imem_req is high
- imem_rvalid  in  1  response valid, one cycle, at least 1 cycle after imem_req rises
- imem_rdata  in  32  instruction word, valid with imem_rvalid
- instruction  out  32  latched instruction word to decode/control
- instr_valid  out  1  instruction and pc are valid for the current instruction
- instr_ready  in  1  core retires the current instruction this cycle
- pc  out  XLEN  address of the current instruction
- pc_plus4  out  XLEN  pc + 4, mod 2^32, for jal/jalr link write-back
- branch_taken  in  1  conditional branch resolved taken (branch & ALU compare)
- jl  in  1  current instruction is jal
- jlr  in  1  current instruction is jalr
- branch_target  in  XLEN  pc + imm, for branch and jal
- jalr_target  in  XLEN  rs1 + imm from the ALU
- fetch_err  out  1  sticky: misaligned next-PC detected

Behaviour:
- Reset (rst=1 at edge): pc=RESET_PC, state=IDLE, imem_req=0, instr_valid=0, instruction=32'h0000_0013 (NOP), fetch_err=0. Reset overrides every other input and any in-progress fetch. Instruction memory shares rst, so no stale response survives reset.
- States: IDLE, FETCH, HOLD, ERR.
- IDLE: imem_req=0. Unconditionally moves to FETCH next cycle, so the first request rises 1 cycle after rst deasserts.
- FETCH: imem_req=1 and imem_addr=pc. On imem_rvalid: instruction<=imem_rdata, instr_valid<=1, state->HOLD, and imem_req drops the following cycle. Only one outstanding request exists at a time.
- imem_rvalid outside FETCH is ignored and asserts a simulation-only error.
- HOLD: instruction, pc and instr_valid are stable while instr_ready=0.
- On instr_valid && instr_ready, compute next_pc with priority jlr > jl > branch_taken > sequential:
  - jlr: {jalr_target[31:1],1'b0}
  - jl or branch_taken: branch_target
  - otherwise: pc_plus4
- Redirect inputs are sampled only in the handshake cycle and ignored otherwise.
- If next_pc[1:0]==2'b00: pc<=next_pc, instr_valid<=0, state->FETCH, with the new request issued the next cycle.
- If next_pc[1:0]!=2'b00: pc is unchanged, fetch_err<=1, instr_valid<=0, state->ERR.
- ERR: imem_req=0 and instr_valid=0. Leaves only on rst; fetch_err stays set until rst.
- Latency: rvalid in cycle N -> instr_valid=1 in N+1. Handshake in cycle M -> imem_req=1 with the new address in M+1. Minimum of 3 cycles per instruction with a 1-cycle memory.
- pc_plus4 is combinational from pc. 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000 with no flag.
- Simultaneous jl and branch_taken is illegal from decode; priority still applies deterministically.
- Asserting rst in the same cycle as instr_ready or imem_rvalid: reset wins, and neither the response nor the handshake takes effect.

Test Plan:
- Reset/first fetch: RESET_PC=32'h0000_0100, rst high 2 cycles then low -> imem_req rises 1 cycle later with imem_addr=32'h100. With 1-cycle rvalid returning 32'h00500093, instr_valid=1 and instruction=32'h00500093 the next cycle.
- Sequential plus backpressure: hold instr_ready=0 for 5 cycles at pc=32'h100 -> outputs stable and no new imem_req. Then instr_ready=1 with no redirect -> next request imem_addr=32'h104.
- Branch vs jalr priority: at pc=32'h200 drive branch_taken=1, branch_target=32'h180, jlr=1, jalr_target=32'h305 with handshake -> next imem_addr=32'h304, fetch_err=0.
- Misaligned target: jl=1, branch_target=32'h202 with handshake -> fetch_err=1, state ERR, imem_req stays 0, pc unchanged. Pulse rst -> fetch_err=0 and fetch restarts at RESET_PC.
- Reset mid-fetch: assert rst while imem_req=1, before rvalid -> next cycle imem_req=0, instr_valid=0, pc=RESET_PC. A late imem_rvalid during IDLE is ignored and instruction remains 32'h00000013.
- Wrap-around: with pc=32'hFFFF_FFFC, pc_plus4=0. Handshake with no redirect -> next imem_addr=32'h0000_0000.
